shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_ctrl_pkg.sv | 19 +
 rtl/shift_bit_counter.sv | 38 +++
 rtl/shift_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the shift-register sequencing controller:
// FSM state encoding, register mode codes and the default data width.
package shift_ctrl_pkg;

    localparam int DEF_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

endpackage

// File: rtl/shift_bit_counter.sv
// Loadable down-counter that tracks the remaining shift cycles of a command.
// Decrement saturates at zero; load has priority over decrement.
module shift_bit_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: count_d gets a default before any branch so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for an external universal shift register: parallel-loads a word,
// shifts it a bounded number of cycles, streams the shifted-out bits and captures the result.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic             abort,
    output logic [1:0]       mode,
    output logic [WIDTH-1:0] par_out,
    output logic             right_fill,
    output logic             left_fill,
    input  logic [WIDTH-1:0] q_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic             aborted,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic             fill_q, fill_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             aborted_q, aborted_d;

    logic [CW-1:0]    eff;
    logic             accept;
    logic             active;
    logic             cnt_zero;

    // A request longer than the register is clamped: every bit has left by then.
    always_comb begin
        if (int'(cmd_count) > WIDTH) begin
            eff = CW'(WIDTH);
        end else begin
            eff = CW'(cmd_count);
        end
    end

    assign accept = cmd_valid && (state_q == IDLE);
    assign active = (state_q == LOAD) || (state_q == SHIFT);

    // Loaded with eff on acceptance and decremented once in LOAD, so SHIFT
    // runs while the count walks eff-1 .. 0 and exits on the zero cycle.
    shift_bit_counter #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (eff),
        .dec      (active),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        fill_d    = fill_q;
        data_d    = data_q;
        result_d  = result_q;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = LOAD;
                    dir_d   = cmd_dir;
                    fill_d  = cmd_fill;
                    data_d  = cmd_data;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = cnt_zero ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                result_d = q_in;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            fill_q    <= 1'b0;
            data_q    <= '0;
            result_q  <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            fill_q    <= fill_d;
            data_q    <= data_d;
            result_q  <= result_d;
            aborted_q <= aborted_d;
        end
    end

    // An abort freezes the register in the cancelling cycle as well.
    always_comb begin
        mode = MODE_HOLD;
        case (state_q)
            LOAD:    mode = MODE_LOAD;
            SHIFT:   mode = dir_q ? MODE_LEFT : MODE_RIGHT;
            default: mode = MODE_HOLD;
        endcase
        if (abort && active) begin
            mode = MODE_HOLD;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign par_out    = data_q;
    assign right_fill = fill_q;
    assign left_fill  = fill_q;
    assign ser_valid  = (state_q == SHIFT);
    assign ser_out    = (state_q == SHIFT) ? (dir_q ? q_in[WIDTH-1] : q_in[0]) : 1'b0;
    assign done       = (state_q == DONE);
    assign aborted    = aborted_q;
    assign result     = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: models the controlled shift register,
// scoreboards per-cycle expectations and the captured result.
module tb_shift_seq_ctrl;

    localparam int W  = 5;
    localparam int CN = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [CN-1:0] cmd_count;
    logic [W-1:0]  cmd_data;
    logic          cmd_fill;
    logic          abort;
    logic [1:0]    mode;
    logic [W-1:0]  par_out;
    logic          right_fill;
    logic          left_fill;
    logic [W-1:0]  q_in;
    logic          ser_out;
    logic          ser_valid;
    logic          done;
    logic          aborted;
    logic [W-1:0]  result;

    typedef struct packed {
        logic [1:0] mode;
        logic       sv;
        logic       so;
        logic       dn;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] res_q[$];
    logic [W-1:0] last_result;
    logic [W-1:0] reg_q;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(W), .CNT_W(CN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_count  (cmd_count),
        .cmd_data   (cmd_data),
        .cmd_fill   (cmd_fill),
        .abort      (abort),
        .mode       (mode),
        .par_out    (par_out),
        .right_fill (right_fill),
        .left_fill  (left_fill),
        .q_in       (q_in),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .done       (done),
        .aborted    (aborted),
        .result     (result)
    );

    // Universal shift register driven by the controller; right shift moves toward bit 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q <= '0;
        end else begin
            case (mode)
                2'b01:   reg_q <= {right_fill, reg_q[W-1:1]};
                2'b10:   reg_q <= {reg_q[W-2:0], left_fill};
                2'b11:   reg_q <= par_out;
                default: reg_q <= reg_q;
            endcase
        end
    end
    assign q_in = reg_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int push_exp(input logic dir, input logic [CN-1:0] cnt,
                                    input logic [W-1:0] data, input logic fill);
        int           eff;
        logic [W-1:0] v;
        eff = (int'(cnt) > W) ? W : int'(cnt);
        v   = data;
        exp_q.push_back('{mode: 2'b11, sv: 1'b0, so: 1'b0, dn: 1'b0});
        for (int i = 0; i < eff; i++) begin
            exp_q.push_back('{mode: (dir ? 2'b10 : 2'b01), sv: 1'b1,
                              so: (dir ? v[W-1] : v[0]), dn: 1'b0});
            v = dir ? {v[W-2:0], fill} : {fill, v[W-1:1]};
        end
        exp_q.push_back('{mode: 2'b00, sv: 1'b0, so: 1'b0, dn: 1'b1});
        res_q.push_back(v);
        return eff;
    endfunction

    // Called between a negedge and the following posedge; returns at the negedge of the first IDLE cycle.
    task automatic run_cmd(input logic dir, input logic [CN-1:0] cnt, input logic [W-1:0] data,
                           input logic fill, input logic hold, input logic b2b);
        int           n = 0;
        int           eff;
        int           cyc = 0;
        int           done_at = -1;
        exp_t         e;
        logic [W-1:0] r;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        if (b2b) check("b2b_first_idle", n, 0);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = cnt;
        cmd_data  = data;
        cmd_fill  = fill;
        eff = push_exp(dir, cnt, data, fill);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            e = exp_q.pop_front();
            check("mode", mode, e.mode);
            check("ser_valid", ser_valid, e.sv);
            check("ser_out", ser_out, e.so);
            check("done", done, e.dn);
            check("busy_not_ready", cmd_ready, 0);
            check("par_out", par_out, data);
            check("right_fill", right_fill, fill);
            check("left_fill", left_fill, fill);
            check("no_aborted", aborted, 0);
            if (done && done_at < 0) done_at = cyc;
        end
        check("done_latency", done_at, eff + 2);
        @(negedge clk);
        r = res_q.pop_front();
        check("result", result, r);
        check("idle_done_low", done, 0);
        check("idle_ready", cmd_ready, 1);
        check("idle_mode", mode, 0);
        last_result = r;
    endtask

    task automatic run_abort();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_count = 3'd3;
        cmd_data  = 5'b11001;
        cmd_fill  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("ab_load_mode", mode, 2'b11);
        @(negedge clk);
        check("ab_shift1_mode", mode, 2'b01);
        @(negedge clk);
        check("ab_shift2_valid", ser_valid, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("ab_pulse", aborted, 1);
        check("ab_mode", mode, 0);
        check("ab_no_done", done, 0);
        check("ab_ready", cmd_ready, 1);
        check("ab_ser_valid", ser_valid, 0);
        check("ab_result", result, last_result);
        @(negedge clk);
        check("ab_pulse_end", aborted, 0);
        check("ab_no_done2", done, 0);
        check("ab_result2", result, last_result);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_ignored", aborted, 0);
        check("idle_abort_ready", cmd_ready, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_ready"}, cmd_ready, 1);
        check({tag, "_par"}, par_out, 0);
        check({tag, "_rfill"}, right_fill, 0);
        check({tag, "_lfill"}, left_fill, 0);
        check({tag, "_ser"}, ser_out, 0);
        check({tag, "_serv"}, ser_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_result"}, result, 0);
    endtask

    task automatic run_reset_mid();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_count = 3'd4;
        cmd_data  = 5'b01011;
        cmd_fill  = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pre_shift", ser_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        last_result = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
            check("rst_no_aborted", aborted, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_dir     = 1'b0;
        cmd_count   = '0;
        cmd_data    = '0;
        cmd_fill    = 1'b0;
        abort       = 1'b0;
        last_result = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(1'b0, 3'd2, 5'b10110, 1'b0, 1'b0, 1'b0);
        check("req037_result", last_result, 5'b00101);
        run_cmd(1'b1, 3'd3, 5'b10110, 1'b1, 1'b0, 1'b0);
        check("req038_result", last_result, 5'b10111);
        run_cmd(1'b0, 3'd0, 5'b10011, 1'b1, 1'b0, 1'b0);
        check("count0_result", last_result, 5'b10011);
        run_cmd(1'b1, 3'd7, 5'b01101, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b0, 3'd5, 5'b11111, 1'b0, 1'b0, 1'b0);
        run_cmd(1'b1, 3'd1, 5'b11100, 1'b0, 1'b1, 1'b0);
        run_cmd(1'b0, 3'd4, 5'b00111, 1'b1, 1'b0, 1'b1);

        run_abort();

        for (int i = 0; i < 6; i++) begin
            run_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        run_reset_mid();
        run_cmd(1'b0, 3'd3, 5'b10101, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
